ysyx_040729_exe_mdu: RTL and testbench
======================================

Name: ysyx_040729_exe_mdu

Overview:
- Iterative multiply/divide responder for the EXE stage. Executes RV64M operations: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms.
- The EXE stage raises a request with operands already forwarded. The unit holds `mdu_busy` high, which stalls the pipeline, until the result is ready.
- The result is then held until the pipeline advances on `exe_flow`.
- Sits beside the single-cycle ALU; its result is muxed onto ALU_result when func7==7'b0000001 on OP/OP-32.

Parameters:
- DATA_WIDTH, 64, operand/result width; must be even and >=32.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- mdu_req  input  1  EXE holds an M-extension instruction, level, held while busy
- mdu_kill  input  1  flush/mem_hazard: abandon current op, return to IDLE
- exe_flow  input  1  pipeline advances this cycle (consumer accepts result)
- mdu_func3  input  3  RV func3 selecting the operation
- mdu_len_dw  input  1  1 = 64-bit op, 0 = W op (32-bit)
- src1  input  DATA_WIDTH  forwarded rs1 value
- src2  input  DATA_WIDTH  forwarded rs2 value
- mdu_busy  output  1  stall request to pipeline
- mdu_valid  output  1  result valid (state DONE)
- mdu_result  output  DATA_WIDTH  operation result

Behaviour:
- Reset (async, any time, including mid-op): state=IDLE, counter=0, result register=0, mdu_valid=0, mdu_busy=0.
- States:
  - IDLE, CALC, DONE.
- IDLE:
  - mdu_busy = mdu_req & ~mdu_kill, combinational, so the stall appears in the request cycle.
  - On mdu_req & ~mdu_kill, latch operands/func3/len_dw.
  - Go to CALC with counter = N, where N = DATA_WIDTH if len_dw else 32.
  - Special cases go straight to DONE:
    - Divide/remainder with divisor==0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
    - Signed overflow (dividend = most-negative, divisor = -1): DIV = dividend, REM = 0.
    - For W ops, divisor and overflow checks use the low 32 bits.
- CALC:
  - mdu_busy=1; one iteration per cycle; counter decrements; at counter==1 go to DONE.
  - Latency from acceptance to mdu_valid = N+1 cycles (65 for 64-bit, 33 for W); special cases = 1 cycle.
- Multiply:
  - Radix-2 shift-add on operand magnitudes into a 2N-bit accumulator.
  - Signed-ness per func3: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Final product is negated if operand signs differ.
  - MUL returns low N bits; MULH* return high N bits.
- Divide:
  - Restoring shift-subtract on magnitudes; DIV/REM signed, DIVU/REMU unsigned.
  - Quotient sign = sign1^sign2; remainder sign = dividend sign.
- W ops:
  - Operate on src[31:0] only; the 32-bit result is sign-extended to DATA_WIDTH, including DIVUW/REMUW.
  - func3 001/010/011 with len_dw=0 execute as MULW.
- DONE:
  - mdu_valid=1, mdu_busy=0, mdu_result stable.
  - On exe_flow go to IDLE; otherwise hold indefinitely.
  - The next request is only sampled in IDLE, the cycle after exe_flow, so the same instruction is never executed twice.
- mdu_kill:
  - In any state, forces IDLE next cycle and clears mdu_valid; mdu_busy drops to 0 in the kill cycle.
  - kill has priority over exe_flow and mdu_req.
- mdu_result is 0 outside DONE.
- Operand changes on src1/src2 after acceptance are ignored, since operands are latched.

Test Plan:
- Reset asserted during CALC of a 64-bit MUL -> mdu_busy=0 and mdu_valid=0 immediately (async); the next req restarts cleanly.
- MUL 64-bit, src1=3, src2=-5:
  - mdu_busy=1 from the request cycle.
  - mdu_valid rises 65 cycles later with result 0xFFFF_FFFF_FFFF_FFF1.
  - Result is held with exe_flow=0 for 10 cycles, then IDLE after exe_flow.
- MULH -1×-1 -> 0; MULHU 0xFFFF_FFFF_FFFF_FFFF×2 -> 1; MULHSU -1×2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV/REM corner cases:
  - DIV -7/2 -> -3 and REM -7/2 -> -1.
  - DIVU 7/0 -> all ones in 1 cycle; REMU 7/0 -> 7.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 and REM -> 0.
- W ops:
  - DIVUW src1=0xFFFF_FFFF_8000_0000, src2=1 -> 0xFFFF_FFFF_8000_0000 after 33 cycles.
  - MULW 0x7FFF_FFFF×2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Kill and back-to-back handshake:
  - mdu_kill at CALC cycle 10 -> IDLE next cycle, no mdu_valid.
  - Back-to-back requests with exe_flow pulsed in DONE -> exactly one result per instruction.

Source files
------------

// File: rtl/ysyx_040729_exe_mdu.sv
// Iterative RV64M multiply/divide unit for the EXE stage.
// Radix-2 shift-add multiply and restoring shift-subtract divide, one
// iteration per cycle on operand magnitudes; signs are applied at the end.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a request; stall is raised combinationally
// S_CALC | iterating, counter counts N..1
// S_DONE | result valid and held until the pipeline advances
module ysyx_040729_exe_mdu #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mdu_req,
  input  logic                  mdu_kill,
  input  logic                  exe_flow,
  input  logic [2:0]            mdu_func3,
  input  logic                  mdu_len_dw,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  output logic                  mdu_busy,
  output logic                  mdu_valid,
  output logic [DATA_WIDTH-1:0] mdu_result
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] N_DW = CW'(DW);
  localparam logic [CW-1:0] N_W  = CW'(32);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   result_q, result_d;
  logic            div_q, div_d;
  logic            rsel_q, rsel_d;
  logic            hi_q, hi_d;
  logic            dw_q, dw_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic            busy;

  // Extend the low word to full width, sign- or zero-filling the upper bits.
  function automatic logic [DW-1:0] ext32(input logic [DW-1:0] x, input logic sgn);
    logic [DW-1:0] r;
    r = x;
    for (int i = 32; i < DW; i++) r[i] = sgn & x[31];
    return r;
  endfunction

  // Word ops always deliver a sign-extended 32-bit result.
  function automatic logic [DW-1:0] fin(input logic dw, input logic [DW-1:0] x);
    return dw ? x : ext32(x, 1'b1);
  endfunction

  logic          req_s1, req_s2, neg_a, neg_b, div_zero, div_ovf;
  logic [DW-1:0] opa, opb, mag_a, mag_b, min_neg, spec_res;

  // Request decode: operand signedness, magnitudes and divide special cases.
  always_comb begin
    if (mdu_func3[2]) begin
      req_s1 = ~mdu_func3[0];
      req_s2 = ~mdu_func3[0];
    end else begin
      // any W multiply is MULW, whose low word does not depend on signedness
      req_s1 = ~mdu_len_dw | (mdu_func3[1:0] != 2'b11);
      req_s2 = ~mdu_len_dw | ~mdu_func3[1];
    end
    opa = mdu_len_dw ? src1 : ext32(src1, req_s1);
    opb = mdu_len_dw ? src2 : ext32(src2, req_s2);
    neg_a = req_s1 & opa[DW-1];
    neg_b = req_s2 & opb[DW-1];
    mag_a = neg_a ? -opa : opa;
    mag_b = neg_b ? -opb : opb;
    min_neg = '0;
    min_neg[DW-1] = 1'b1;
    if (!mdu_len_dw) begin
      for (int i = 31; i < DW; i++) min_neg[i] = 1'b1;
    end
    div_zero = (opb == '0);
    div_ovf  = req_s1 & (opa == min_neg) & (&opb);
    if (div_zero) spec_res = mdu_func3[1] ? opa : '1;
    else          spec_res = mdu_func3[1] ? '0  : opa;
    spec_res = fin(mdu_len_dw, spec_res);
  end

  logic [2*DW-1:0] acc_n, prod;
  logic [DW:0]     trial, diff;
  logic [DW-1:0]   rem_n, quo_n, quot, remv, mul_res, div_res, calc_res;

  // One datapath iteration plus the sign fix-up used on the final step.
  always_comb begin
    acc_n = acc_q + (mplier_q[0] ? mcand_q : '0);
    trial = {rem_q, quo_q[DW-1]};
    diff  = trial - {1'b0, dvs_q};
    rem_n = diff[DW] ? trial[DW-1:0] : diff[DW-1:0];
    quo_n = {quo_q[DW-2:0], ~diff[DW]};
    prod    = negq_q ? -acc_n : acc_n;
    mul_res = hi_q ? prod[2*DW-1:DW] : prod[DW-1:0];
    quot    = negq_q ? -quo_n : quo_n;
    remv    = negr_q ? -rem_n : rem_n;
    div_res = rsel_q ? remv : quot;
    calc_res = fin(dw_q, div_q ? div_res : mul_res);
  end

  // Next-state, operand latching and stall generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    div_d    = div_q;
    rsel_d   = rsel_q;
    hi_d     = hi_q;
    dw_d     = dw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = mdu_req;
        if (mdu_req) begin
          div_d    = mdu_func3[2];
          rsel_d   = mdu_func3[1];
          hi_d     = mdu_len_dw & (mdu_func3[1:0] != 2'b00);
          dw_d     = mdu_len_dw;
          negq_d   = neg_a ^ neg_b;
          negr_d   = neg_a;
          acc_d    = '0;
          mcand_d  = {{DW{1'b0}}, mag_a};
          mplier_d = mag_b;
          // word dividends are MSB-aligned so 32 steps leave the quotient low
          quo_d    = mdu_len_dw ? mag_a : (mag_a << (DW - 32));
          rem_d    = '0;
          dvs_d    = mag_b;
          if (mdu_func3[2] && (div_zero || div_ovf)) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = mdu_len_dw ? N_DW : N_W;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (div_q) begin
          quo_d = quo_n;
          rem_d = rem_n;
        end else begin
          acc_d    = acc_n;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == CW'(1)) begin
          result_d = calc_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (exe_flow) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (mdu_kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      busy    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      div_q    <= 1'b0;
      rsel_q   <= 1'b0;
      hi_q     <= 1'b0;
      dw_q     <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      div_q    <= div_d;
      rsel_q   <= rsel_d;
      hi_q     <= hi_d;
      dw_q     <= dw_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

  // Reset also masks the combinational stall so it drops the instant reset rises.
  assign mdu_busy   = busy & ~reset;
  assign mdu_valid  = (state_q == S_DONE);
  assign mdu_result = mdu_valid ? result_q : '0;

endmodule

// File: tb/tb_ysyx_040729_exe_mdu.sv
// Randomized bench for ysyx_040729_exe_mdu against an arithmetic reference.
module tb_ysyx_040729_exe_mdu;

  logic        clock = 1'b0;
  logic        reset, mdu_req, mdu_kill, exe_flow, mdu_len_dw;
  logic [2:0]  mdu_func3;
  logic [63:0] src1, src2;
  logic        mdu_busy, mdu_valid;
  logic [63:0] mdu_result;

  int n_checks = 0, n_errors = 0, n_issued = 0, n_consumed = 0;

  ysyx_040729_exe_mdu #(.DATA_WIDTH(64)) dut (
    .clock(clock), .reset(reset), .mdu_req(mdu_req), .mdu_kill(mdu_kill),
    .exe_flow(exe_flow), .mdu_func3(mdu_func3), .mdu_len_dw(mdu_len_dw),
    .src1(src1), .src2(src2), .mdu_busy(mdu_busy), .mdu_valid(mdu_valid),
    .mdu_result(mdu_result)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mdu_valid && exe_flow && !mdu_kill && !reset) n_consumed++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic dw,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [31:0]  a32, b32, r32;
    logic [63:0]  r;
    int           ia, ib;
    longint       sa, sb;
    if (!dw) begin
      a32 = a[31:0]; b32 = b[31:0]; ia = a32; ib = b32;
      if (!f3[2]) r32 = a32 * b32;
      else if (b32 == 0) r32 = f3[1] ? a32 : 32'hFFFF_FFFF;
      else begin
        case (f3[1:0])
          2'b00: if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32; else r32 = ia / ib;
          2'b01: r32 = a32 / b32;
          2'b10: if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 0; else r32 = ia % ib;
          default: r32 = a32 % b32;
        endcase
      end
      return {{32{r32[31]}}, r32};
    end
    if (!f3[2]) begin
      ea = {{64{(f3 != 3'b011) & a[63]}}, a};
      eb = {{64{(f3[1] == 1'b0) & b[63]}}, b};
      p = ea * eb;
      return (f3 == 3'b000) ? p[63:0] : p[127:64];
    end
    sa = a; sb = b;
    if (b == 0) return f3[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    case (f3[1:0])
      2'b00: if (a == 64'h8000_0000_0000_0000 && b == '1) r = a; else r = sa / sb;
      2'b01: r = a / b;
      2'b10: if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0; else r = sa % sb;
      default: r = a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic dw,
                                 input logic [63:0] a, input logic [63:0] b);
    logic bz, ovf;
    if (dw) begin
      bz  = (b == 0);
      ovf = !f3[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      bz  = (b[31:0] == 0);
      ovf = !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end
    if (f3[2] && (bz || ovf)) return 1;
    return dw ? 65 : 33;
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic dw, input logic [63:0] a,
                       input logic [63:0] b, input int hold, input logic b2b, input string tag);
    logic [63:0] exp;
    int          exp_lat, cyc;
    logic        gap, unstable;
    exp = ref_res(f3, dw, a, b);
    exp_lat = ref_lat(f3, dw, a, b);
    mdu_req = 1'b1; mdu_func3 = f3; mdu_len_dw = dw; src1 = a; src2 = b;
    #1 check({tag, "_busy_req"}, 64'(mdu_busy), 64'(1));
    cyc = 0; gap = 1'b0; unstable = 1'b0;
    while (!mdu_valid && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      src1 = {$urandom, $urandom};
      src2 = {$urandom, $urandom};
      if (!mdu_valid && !mdu_busy) gap = 1'b1;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, mdu_result, exp);
    check({tag, "_busy_done"}, 64'(mdu_busy), 64'(0));
    check({tag, "_busy_gap"}, 64'(gap), 64'(0));
    repeat (hold) begin
      @(posedge clock); #1;
      if (!mdu_valid || mdu_result !== exp || mdu_busy) unstable = 1'b1;
    end
    if (hold > 0) check({tag, "_hold"}, 64'(unstable), 64'(0));
    exe_flow = 1'b1;
    @(posedge clock); #1;
    exe_flow = 1'b0;
    if (!b2b) mdu_req = 1'b0;
    check({tag, "_flow_idle"}, {63'(0), mdu_valid} | mdu_result, 64'(0));
    n_issued++;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 11))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'h0000_0000_7FFF_FFFF;
      6: return 64'(32'hFFFF_FFFF);
      7: return 64'($urandom_range(0, 50));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bad;
    reset = 1'b1; mdu_req = 1'b0; mdu_kill = 1'b0; exe_flow = 1'b0;
    mdu_func3 = 3'b000; mdu_len_dw = 1'b1; src1 = '0; src2 = '0;
    #2;
    check("rst_busy", 64'(mdu_busy), 64'(0));
    check("rst_valid", 64'(mdu_valid), 64'(0));
    check("rst_result", mdu_result, 64'(0));
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // async reset in the middle of a 64-bit multiply
    mdu_req = 1'b1; mdu_func3 = 3'b000; mdu_len_dw = 1'b1; src1 = 64'd9; src2 = 64'd7;
    repeat (20) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(mdu_busy), 64'(0));
    check("midrst_valid", 64'(mdu_valid), 64'(0));
    check("midrst_result", mdu_result, 64'(0));
    mdu_req = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    do_op(3'b000, 1'b1, 64'd9, 64'd7, 0, 1'b0, "after_rst");

    // directed cases, chained back to back
    do_op(3'b000, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 10, 1'b1, "mul_3x-5");
    do_op(3'b001, 1'b1, '1, '1, 1, 1'b1, "mulh_m1m1");
    do_op(3'b011, 1'b1, '1, 64'd2, 0, 1'b1, "mulhu");
    do_op(3'b010, 1'b1, '1, 64'd2, 2, 1'b1, "mulhsu");
    do_op(3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1'b1, "div_m7_2");
    do_op(3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1'b1, "rem_m7_2");
    do_op(3'b101, 1'b1, 64'd7, 64'd0, 3, 1'b1, "divu_by0");
    do_op(3'b111, 1'b1, 64'd7, 64'd0, 0, 1'b1, "remu_by0");
    do_op(3'b100, 1'b1, 64'h8000_0000_0000_0000, '1, 0, 1'b1, "div_ovf");
    do_op(3'b110, 1'b1, 64'h8000_0000_0000_0000, '1, 0, 1'b1, "rem_ovf");
    do_op(3'b101, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'd1, 0, 1'b1, "divuw");
    do_op(3'b000, 1'b0, 64'h7FFF_FFFF, 64'd2, 0, 1'b0, "mulw");

    // kill ten cycles into a calculation
    mdu_req = 1'b1; mdu_func3 = 3'b000; mdu_len_dw = 1'b1; src1 = 64'd5; src2 = 64'd6;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1 mdu_kill = 1'b1;
    #1 check("kill_busy", 64'(mdu_busy), 64'(0));
    @(posedge clock); #1;
    mdu_kill = 1'b0; mdu_req = 1'b0;
    check("kill_idle", {62'(0), mdu_valid, mdu_busy}, 64'(0));
    bad = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      if (mdu_valid || mdu_busy) bad = 1'b1;
    end
    check("kill_no_valid", 64'(bad), 64'(0));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        mdu_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    mdu_req = 1'b0;
    @(posedge clock); #1;
    check("one_result_per_op", 64'(n_consumed), 64'(n_issued));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
